ctrl_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle main decoder. It decodes the 6-bit opcode in ID and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. It also detects load-use hazards and inserts bubbles on stall, flush or illegal opcode. It sits between the IF/ID register and the datapath stage registers of the pipelined MIPS core.

---
 rtl/ctrl_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined main decoder with load-use stall and ID/EX, EX/MEM, MEM/WB control registers
//
// Decodes the opcode sitting in ID and carries the resulting control bundle
// through the ID/EX, EX/MEM and MEM/WB stage registers. A load in EX whose
// destination is read by the instruction in ID raises stall, and a bubble is
// loaded into ID/EX on flush, stall, empty ID slot or illegal opcode.
//
// Parameters:
//   REG_AW    register-number width
//   HAS_JUMP  1: opcode 000010 decodes as j; 0: it is illegal
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   id_valid    ID holds a real instruction
//   id_opcode   opcode of the instruction in ID
//   id_rs/rt/rd register fields of the instruction in ID
//   flush       taken branch/jump in EX; kills the instruction in ID
//   stall       load-use hazard, hold PC and IF/ID (combinational)
//   ex_ctrl     ID/EX bundle {ExtOp, Jump, bgtz, bne, beq, MemtoReg, MemRd,
//               MemWr, ALUSrc, RegWr, RegDst, aluop[2:0]}
//   ex_wreg     destination register in EX (0 when nothing is written)
//   ex_illegal  instruction in EX had an illegal opcode
//   mem_ctrl    EX/MEM bundle {MemtoReg, MemRd, MemWr, RegWr, Jump}
//   mem_wreg    destination register in MEM
//   wb_ctrl     MEM/WB bundle {MemtoReg, RegWr}
//   wb_wreg     destination register in WB

module ctrl_pipe #(
    parameter int REG_AW   = 5,
    parameter bit HAS_JUMP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic [13:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_illegal,
    output logic [4:0]        mem_ctrl,
    output logic [REG_AW-1:0] mem_wreg,
    output logic [1:0]        wb_ctrl,
    output logic [REG_AW-1:0] wb_wreg
);

    // Opcodes understood by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Bit positions inside the 14-bit ID/EX bundle
    localparam int B_EXTOP    = 13;
    localparam int B_JUMP     = 12;
    localparam int B_BGTZ     = 11;
    localparam int B_BNE      = 10;
    localparam int B_BEQ      = 9;
    localparam int B_MEMTOREG = 8;
    localparam int B_MEMRD    = 7;
    localparam int B_MEMWR    = 6;
    localparam int B_ALUSRC   = 5;
    localparam int B_REGWR    = 4;
    localparam int B_REGDST   = 3;

    // Bit positions inside the 5-bit EX/MEM bundle
    localparam int M_MEMTOREG = 4;
    localparam int M_REGWR    = 1;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b100;

    logic [13:0]       raw_ctrl;
    logic              dec_legal;
    logic              uses_rs;
    logic              uses_rt;
    logic [REG_AW-1:0] sel_reg;
    logic              wr_en;
    logic [13:0]       dec_ctrl;
    logic [REG_AW-1:0] dec_wreg;
    logic              hazard_rs;
    logic              hazard_rt;
    logic              bubble;

    // ------------------------------------------------------------------
    // Opcode decode (same truth table as the single-cycle decoder), plus
    // which source fields the instruction actually reads for hazard checks.
    // ------------------------------------------------------------------
    always_comb begin
        raw_ctrl  = '0;
        dec_legal = 1'b1;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                raw_ctrl[B_REGDST] = 1'b1;
                raw_ctrl[B_REGWR]  = 1'b1;
                raw_ctrl[2:0]      = ALU_FUNC;
                uses_rs            = 1'b1;
                uses_rt            = 1'b1;
            end
            OP_LW: begin
                raw_ctrl[B_ALUSRC]   = 1'b1;
                raw_ctrl[B_REGWR]    = 1'b1;
                raw_ctrl[B_MEMRD]    = 1'b1;
                raw_ctrl[B_MEMTOREG] = 1'b1;
                raw_ctrl[B_EXTOP]    = 1'b1;
                raw_ctrl[2:0]        = ALU_ADD;
                uses_rs              = 1'b1;
            end
            OP_SW: begin
                raw_ctrl[B_ALUSRC] = 1'b1;
                raw_ctrl[B_MEMWR]  = 1'b1;
                raw_ctrl[B_EXTOP]  = 1'b1;
                raw_ctrl[2:0]      = ALU_ADD;
                uses_rs            = 1'b1;
                uses_rt            = 1'b1;
            end
            OP_BEQ: begin
                raw_ctrl[B_BEQ]   = 1'b1;
                raw_ctrl[B_EXTOP] = 1'b1;
                raw_ctrl[2:0]     = ALU_SUB;
                uses_rs           = 1'b1;
                uses_rt           = 1'b1;
            end
            OP_BNE: begin
                raw_ctrl[B_BNE]   = 1'b1;
                raw_ctrl[B_EXTOP] = 1'b1;
                raw_ctrl[2:0]     = ALU_SUB;
                uses_rs           = 1'b1;
                uses_rt           = 1'b1;
            end
            OP_BGTZ: begin
                // bgtz compares rs against zero; rt is not a source
                raw_ctrl[B_BGTZ]  = 1'b1;
                raw_ctrl[B_EXTOP] = 1'b1;
                raw_ctrl[2:0]     = ALU_SUB;
                uses_rs           = 1'b1;
            end
            OP_ADDI: begin
                raw_ctrl[B_ALUSRC] = 1'b1;
                raw_ctrl[B_REGWR]  = 1'b1;
                raw_ctrl[2:0]      = ALU_ADD;
                uses_rs            = 1'b1;
            end
            OP_J: begin
                if (HAS_JUMP) begin
                    raw_ctrl[B_JUMP] = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Destination register. A write to register 0 is turned into no write
    // at all, so downstream forwarding and hazard logic never see r0.
    // ------------------------------------------------------------------
    always_comb begin
        sel_reg          = raw_ctrl[B_REGDST] ? id_rd : id_rt;
        wr_en            = raw_ctrl[B_REGWR] && (sel_reg != '0);
        dec_wreg         = wr_en ? sel_reg : '0;
        dec_ctrl         = raw_ctrl;
        dec_ctrl[B_REGWR] = wr_en;
    end

    // ------------------------------------------------------------------
    // Load-use hazard: a load in EX whose result is read by ID. flush kills
    // the ID instruction, so there is nothing to hold for it.
    // ------------------------------------------------------------------
    always_comb begin
        hazard_rs = uses_rs && (ex_wreg == id_rs);
        hazard_rt = uses_rt && (ex_wreg == id_rt);
        stall     = ex_ctrl[B_MEMRD] && (ex_wreg != '0) && id_valid && !flush
                    && (hazard_rs || hazard_rt);
    end

    assign bubble = flush || stall || !id_valid;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl    <= '0;
            ex_wreg    <= '0;
            ex_illegal <= 1'b0;
        end else if (bubble) begin
            ex_ctrl    <= '0;
            ex_wreg    <= '0;
            ex_illegal <= 1'b0;
        end else if (!dec_legal) begin
            // Illegal slot travels as a bubble; only the flag marks it
            ex_ctrl    <= '0;
            ex_wreg    <= '0;
            ex_illegal <= 1'b1;
        end else begin
            ex_ctrl    <= dec_ctrl;
            ex_wreg    <= dec_wreg;
            ex_illegal <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM and MEM/WB registers advance every cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ctrl <= '0;
            mem_wreg <= '0;
            wb_ctrl  <= '0;
            wb_wreg  <= '0;
        end else begin
            mem_ctrl <= {ex_ctrl[B_MEMTOREG], ex_ctrl[B_MEMRD], ex_ctrl[B_MEMWR],
                         ex_ctrl[B_REGWR], ex_ctrl[B_JUMP]};
            mem_wreg <= ex_wreg;
            wb_ctrl  <= {mem_ctrl[M_MEMTOREG], mem_ctrl[M_REGWR]};
            wb_wreg  <= mem_wreg;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed self-checking bench for ctrl_pipe (HAS_JUMP=1 and HAS_JUMP=0 instances)

module tb_ctrl_pipe;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       flush;

    logic        stall_j,   stall_nj;
    logic [13:0] ex_ctrl_j, ex_ctrl_nj;
    logic [4:0]  ex_wreg_j, ex_wreg_nj;
    logic        ex_ill_j,  ex_ill_nj;
    logic [4:0]  mem_ctrl_j, mem_ctrl_nj;
    logic [4:0]  mem_wreg_j, mem_wreg_nj;
    logic [1:0]  wb_ctrl_j, wb_ctrl_nj;
    logic [4:0]  wb_wreg_j, wb_wreg_nj;

    int checks;
    int errors;

    // Expected bundles, hand-encoded from the decode table
    localparam logic [13:0] C_RTYPE   = 14'h001C; // RegWr, RegDst, aluop=100
    localparam logic [13:0] C_LW      = 14'h21B0; // ExtOp, MemtoReg, MemRd, ALUSrc, RegWr
    localparam logic [13:0] C_LW_R0   = 14'h21A0; // lw with RegWr cleared
    localparam logic [13:0] C_ADDI    = 14'h0030; // ALUSrc, RegWr
    localparam logic [13:0] C_ADDI_R0 = 14'h0020; // ALUSrc only
    localparam logic [13:0] C_J       = 14'h1000; // Jump

    ctrl_pipe #(.REG_AW(5), .HAS_JUMP(1'b1)) dut_j (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall_j), .ex_ctrl(ex_ctrl_j), .ex_wreg(ex_wreg_j),
        .ex_illegal(ex_ill_j), .mem_ctrl(mem_ctrl_j), .mem_wreg(mem_wreg_j),
        .wb_ctrl(wb_ctrl_j), .wb_wreg(wb_wreg_j)
    );

    ctrl_pipe #(.REG_AW(5), .HAS_JUMP(1'b0)) dut_nj (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall_nj), .ex_ctrl(ex_ctrl_nj), .ex_wreg(ex_wreg_nj),
        .ex_illegal(ex_ill_nj), .mem_ctrl(mem_ctrl_nj), .mem_wreg(mem_wreg_nj),
        .wb_ctrl(wb_ctrl_nj), .wb_wreg(wb_wreg_nj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        drv(1'b1, 6'b000000, 5'd1, 5'd2, 5'd3);
        tick();
        tick();
        checks++; if (ex_ctrl_j !== 14'h0) begin errors++; $display("FAIL reset_ex_ctrl: got %h expected 0", ex_ctrl_j); end
        checks++; if (ex_wreg_j !== 5'd0) begin errors++; $display("FAIL reset_ex_wreg: got %0d expected 0", ex_wreg_j); end
        checks++; if (mem_ctrl_j !== 5'h0 || wb_ctrl_j !== 2'h0) begin errors++; $display("FAIL reset_mem_wb: got %b %b expected 0 0", mem_ctrl_j, wb_ctrl_j); end
        checks++; if (stall_j !== 1'b0 || ex_ill_j !== 1'b0) begin errors++; $display("FAIL reset_stall_ill: got %b %b expected 0 0", stall_j, ex_ill_j); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        drv(1'b1, 6'b000000, 5'd1, 5'd2, 5'd3);
        tick();
        checks++; if (ex_ctrl_j !== C_RTYPE) begin errors++; $display("FAIL rtype_ex_ctrl: got %h expected %h", ex_ctrl_j, C_RTYPE); end
        checks++; if (ex_wreg_j !== 5'd3) begin errors++; $display("FAIL rtype_ex_wreg: got %0d expected 3", ex_wreg_j); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
        checks++; if (ex_ctrl_j !== 14'h0) begin errors++; $display("FAIL rtype_idle_bubble: got %h expected 0", ex_ctrl_j); end
        checks++; if (mem_ctrl_j !== 5'b00010 || mem_wreg_j !== 5'd3) begin errors++; $display("FAIL rtype_mem: got %b/%0d expected 00010/3", mem_ctrl_j, mem_wreg_j); end
        tick();
        checks++; if (wb_ctrl_j !== 2'b01 || wb_wreg_j !== 5'd3) begin errors++; $display("FAIL rtype_wb: got %b/%0d expected 01/3", wb_ctrl_j, wb_wreg_j); end
        tick();
    endtask

    task automatic test_load_use();
        drv(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);
        checks++; if (stall_j !== 1'b0) begin errors++; $display("FAIL lu_no_stall_before: got %b expected 0", stall_j); end
        tick();
        checks++; if (ex_ctrl_j !== C_LW || ex_wreg_j !== 5'd4) begin errors++; $display("FAIL lu_lw_ex: got %h/%0d expected %h/4", ex_ctrl_j, ex_wreg_j, C_LW); end
        drv(1'b1, 6'b000000, 5'd4, 5'd5, 5'd6);
        checks++; if (stall_j !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall_j); end
        tick();
        checks++; if (ex_ctrl_j !== 14'h0 || ex_wreg_j !== 5'd0) begin errors++; $display("FAIL lu_bubble: got %h/%0d expected 0/0", ex_ctrl_j, ex_wreg_j); end
        checks++; if (stall_j !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle: got %b expected 0", stall_j); end
        checks++; if (mem_ctrl_j !== 5'b11010 || mem_wreg_j !== 5'd4) begin errors++; $display("FAIL lu_lw_mem: got %b/%0d expected 11010/4", mem_ctrl_j, mem_wreg_j); end
        tick();
        checks++; if (ex_ctrl_j !== C_RTYPE || ex_wreg_j !== 5'd6) begin errors++; $display("FAIL lu_add_late: got %h/%0d expected %h/6", ex_ctrl_j, ex_wreg_j, C_RTYPE); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_sw_and_r0();
        drv(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);
        tick();
        drv(1'b1, 6'b101011, 5'd1, 5'd4, 5'd0);
        checks++; if (stall_j !== 1'b1) begin errors++; $display("FAIL sw_rt_stall: got %b expected 1", stall_j); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drv(1'b1, 6'b100011, 5'd1, 5'd0, 5'd0);
        tick();
        checks++; if (ex_ctrl_j !== C_LW_R0 || ex_wreg_j !== 5'd0) begin errors++; $display("FAIL lw_r0_ex: got %h/%0d expected %h/0", ex_ctrl_j, ex_wreg_j, C_LW_R0); end
        drv(1'b1, 6'b000000, 5'd0, 5'd0, 5'd6);
        checks++; if (stall_j !== 1'b0) begin errors++; $display("FAIL r0_no_stall: got %b expected 0", stall_j); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_flush();
        drv(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);
        tick();
        drv(1'b1, 6'b000000, 5'd4, 5'd5, 5'd6);
        flush = 1'b1;
        #1;
        checks++; if (stall_j !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall_j); end
        tick();
        checks++; if (ex_ctrl_j !== 14'h0 || ex_ill_j !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %h/%b expected 0/0", ex_ctrl_j, ex_ill_j); end
        drv(1'b1, 6'b111111, 5'd0, 5'd0, 5'd0);
        tick();
        checks++; if (ex_ill_j !== 1'b0) begin errors++; $display("FAIL flush_illegal: got %b expected 0", ex_ill_j); end
        flush = 1'b0;
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_illegal();
        drv(1'b1, 6'b111111, 5'd1, 5'd2, 5'd3);
        tick();
        checks++; if (ex_ill_j !== 1'b1 || ex_ctrl_j !== 14'h0) begin errors++; $display("FAIL ill_111111: got %b/%h expected 1/0", ex_ill_j, ex_ctrl_j); end
        drv(1'b1, 6'b000010, 5'd1, 5'd7, 5'd3);
        tick();
        checks++; if (ex_ill_nj !== 1'b1 || ex_ctrl_nj !== 14'h0) begin errors++; $display("FAIL ill_j_nojump: got %b/%h expected 1/0", ex_ill_nj, ex_ctrl_nj); end
        checks++; if (ex_ill_j !== 1'b0 || ex_ctrl_j !== C_J || ex_wreg_j !== 5'd0) begin errors++; $display("FAIL j_decode: got %b/%h/%0d expected 0/%h/0", ex_ill_j, ex_ctrl_j, ex_wreg_j, C_J); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
        checks++; if (ex_ill_nj !== 1'b0) begin errors++; $display("FAIL ill_pulse_end: got %b expected 0", ex_ill_nj); end
        checks++; if (mem_ctrl_j !== 5'b00001) begin errors++; $display("FAIL j_mem: got %b expected 00001", mem_ctrl_j); end
    endtask

    task automatic test_addi();
        drv(1'b1, 6'b001000, 5'd3, 5'd0, 5'd5);
        tick();
        checks++; if (ex_ctrl_j !== C_ADDI_R0 || ex_wreg_j !== 5'd0) begin errors++; $display("FAIL addi_r0: got %h/%0d expected %h/0", ex_ctrl_j, ex_wreg_j, C_ADDI_R0); end
        drv(1'b1, 6'b001000, 5'd3, 5'd9, 5'd5);
        tick();
        checks++; if (ex_ctrl_j !== C_ADDI || ex_wreg_j !== 5'd9) begin errors++; $display("FAIL addi_r9: got %h/%0d expected %h/9", ex_ctrl_j, ex_wreg_j, C_ADDI); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int nstall;
        nstall = 0;
        drv(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);
        tick();
        drv(1'b1, 6'b100011, 5'd4, 5'd5, 5'd0);
        if (stall_j === 1'b1) nstall++;
        tick();
        if (stall_j === 1'b1) nstall++;
        tick();
        checks++; if (ex_ctrl_j !== C_LW || ex_wreg_j !== 5'd5) begin errors++; $display("FAIL b2b_lw2_ex: got %h/%0d expected %h/5", ex_ctrl_j, ex_wreg_j, C_LW); end
        drv(1'b1, 6'b000000, 5'd5, 5'd2, 5'd6);
        if (stall_j === 1'b1) nstall++;
        tick();
        if (stall_j === 1'b1) nstall++;
        tick();
        checks++; if (nstall !== 2) begin errors++; $display("FAIL b2b_stall_count: got %0d expected 2", nstall); end
        checks++; if (ex_ctrl_j !== C_RTYPE || ex_wreg_j !== 5'd6) begin errors++; $display("FAIL b2b_add_ex: got %h/%0d expected %h/6", ex_ctrl_j, ex_wreg_j, C_RTYPE); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_reset_mid();
        drv(1'b1, 6'b000000, 5'd1, 5'd2, 5'd3);
        tick();
        drv(1'b1, 6'b100011, 5'd1, 5'd7, 5'd0);
        tick();
        checks++; if (mem_ctrl_j !== 5'b00010 || ex_ctrl_j !== C_LW) begin errors++; $display("FAIL mid_pre: got %b/%h expected 00010/%h", mem_ctrl_j, ex_ctrl_j, C_LW); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_ctrl_j !== 5'h0 || wb_ctrl_j !== 2'h0 || ex_ctrl_j !== 14'h0) begin errors++; $display("FAIL mid_async_clear: got %b/%b/%h expected 0/0/0", mem_ctrl_j, wb_ctrl_j, ex_ctrl_j); end
        checks++; if (mem_wreg_j !== 5'd0 || ex_wreg_j !== 5'd0) begin errors++; $display("FAIL mid_async_wreg: got %0d/%0d expected 0/0", mem_wreg_j, ex_wreg_j); end
        drv(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        tick();
        checks++; if (mem_ctrl_j !== 5'h0 || wb_ctrl_j !== 2'h0) begin errors++; $display("FAIL mid_after_release: got %b/%b expected 0/0", mem_ctrl_j, wb_ctrl_j); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        id_valid  = 1'b0;
        id_opcode = 6'b0;
        id_rs     = 5'd0;
        id_rt     = 5'd0;
        id_rd     = 5'd0;
        test_reset();
        test_rtype();
        test_load_use();
        test_sw_and_r0();
        test_flush();
        test_illegal();
        test_addi();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
